// File: rtl/uart_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_config_sequencer
//  Description : Initialisation engine for the 16550 UART ports in the IO
//                window. A Start pulse issues five byte writes per port
//                (divisor latch, line control, FIFO control) over the IO bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_config_sequencer #(
  parameter int          NUM_PORTS   = 4,
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter logic [15:0] PORT_STRIDE = 16'h0010,
  parameter logic [7:0]  LCR_VALUE   = 8'h03,
  parameter logic [7:0]  FCR_VALUE   = 8'h07,
  parameter int          TIMEOUT     = 255,
  parameter int          GAP_CYCLES  = 1
) (
  input  logic                    Clock,
  input  logic                    Reset_L,
  input  logic                    Start_H,
  input  logic [16*NUM_PORTS-1:0] Divisor,
  input  logic                    Bus_Ack_H,
  output logic                    Bus_Req_H,
  output logic [15:0]             Address,
  output logic [7:0]              WriteData,
  output logic                    Busy_H,
  output logic                    Done_H,
  output logic                    Error_H,
  output logic [1:0]              Port_Index
);

  // REQ-cycle counter counts 0..TIMEOUT-1, GAP counter 0..GAP_CYCLES-1
  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP_CYCLES - 1);
  localparam logic [1:0]      c_LAST_PORT = 2'(NUM_PORTS - 1);
  localparam logic [2:0]      c_LAST_STEP = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                  r_state, w_state_nx;
  logic [1:0]              r_port, w_port_nx;
  logic [2:0]              r_step, w_step_nx;
  logic [c_TW-1:0]         r_tmo, w_tmo_nx;
  logic [c_GW-1:0]         r_gap, w_gap_nx;
  logic [16*NUM_PORTS-1:0] r_div, w_div_nx;
  logic [15:0]             r_addr, w_addr_nx;
  logic [7:0]              r_data, w_data_nx;
  logic                    r_done, w_done_nx;
  logic                    r_error, w_error_nx;
  logic                    w_load;
  logic [15:0]             w_base;
  logic [15:0]             w_div_sel;

  // State and datapath registers; bus address/data only change when a new write is launched
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= S_IDLE;
      r_port  <= '0;
      r_step  <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_div   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_port  <= w_port_nx;
      r_step  <= w_step_nx;
      r_tmo   <= w_tmo_nx;
      r_gap   <= w_gap_nx;
      r_div   <= w_div_nx;
      r_done  <= w_done_nx;
      r_error <= w_error_nx;
      if (w_load) begin
        r_addr <= w_addr_nx;
        r_data <= w_data_nx;
      end
    end
  end

  // Next-state logic: launch, ack/timeout handling in REQ, step/port advance after GAP
  always_comb begin
    w_state_nx = r_state;
    w_port_nx  = r_port;
    w_step_nx  = r_step;
    w_tmo_nx   = r_tmo;
    w_gap_nx   = r_gap;
    w_div_nx   = r_div;
    w_done_nx  = r_done;
    w_error_nx = r_error;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start_H) begin
          w_div_nx   = Divisor;
          w_done_nx  = 1'b0;
          w_error_nx = 1'b0;
          w_port_nx  = '0;
          w_step_nx  = '0;
          w_tmo_nx   = '0;
          w_state_nx = S_REQ;
          w_load     = 1'b1;
        end
      end
      S_REQ: begin
        if (Bus_Ack_H) begin
          w_gap_nx   = '0;
          w_state_nx = S_GAP;
        end else if (r_tmo == c_TMO_LAST) begin
          w_error_nx = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_tmo_nx = r_tmo + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap == c_GAP_LAST) begin
          w_tmo_nx = '0;
          if (r_step != c_LAST_STEP) begin
            w_step_nx  = r_step + 3'd1;
            w_state_nx = S_REQ;
            w_load     = 1'b1;
          end else if (r_port != c_LAST_PORT) begin
            w_step_nx  = '0;
            w_port_nx  = r_port + 2'd1;
            w_state_nx = S_REQ;
            w_load     = 1'b1;
          end else begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          w_gap_nx = r_gap + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Address/data of the write about to be launched; registers are even-spaced at base+2n
  always_comb begin
    w_base    = BASE_ADDR + PORT_STRIDE * {14'd0, w_port_nx};
    w_div_sel = r_div[{w_port_nx, 4'b0000} +: 16];
    w_addr_nx = w_base + 16'd6;
    w_data_nx = 8'h80;
    case (w_step_nx)
      3'd1: begin w_addr_nx = w_base;          w_data_nx = w_div_sel[7:0];  end
      3'd2: begin w_addr_nx = w_base + 16'd2;  w_data_nx = w_div_sel[15:8]; end
      3'd3: begin w_addr_nx = w_base + 16'd6;  w_data_nx = LCR_VALUE;       end
      3'd4: begin w_addr_nx = w_base + 16'd4;  w_data_nx = FCR_VALUE;       end
      default: ;
    endcase
  end

  assign Bus_Req_H  = (r_state == S_REQ);
  assign Busy_H     = (r_state != S_IDLE);
  assign Done_H     = r_done;
  assign Error_H    = r_error;
  assign Address    = r_addr;
  assign WriteData  = r_data;
  assign Port_Index = r_port;

endmodule
`default_nettype wire
